// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: opcode constants, the NOP encoding
// and the fetch FSM state type.
package riscv_pkg;

    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO holding {pc, instr} entries; flush empties it in one cycle.
// Push is ignored when full and pop when empty.
module fetch_buffer #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (cnt != CW'(DEPTH));
    assign do_pop  = pop && (cnt != {CW{1'b0}});
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    // Storage array; contents are don't-care while the pointers mark it empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= {AW{1'b0}};
            rd_ptr <= {AW{1'b0}};
            cnt    <= {CW{1'b0}};
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, credit-limited request issue, response
// buffering and redirect flush. Optional counters enabled by FETCH_PERF_EN.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = 32'h0000_0000,
    parameter int               BUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             stall,
    output logic             instr_valid,
    output logic [XLEN-1:0]  instr_pc,
    output logic [31:0]      instr,
    output logic [6:0]       opcode,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_flushes
`endif
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t       state, state_next;
    logic [XLEN-1:0]    pc, pc_next;
    logic [CW-1:0]      outstanding, outstanding_next;
    logic [CW-1:0]      discard, discard_next;
    logic [CW-1:0]      count;
    logic [XLEN+31:0]   head;
    logic               accept;
    logic               push;
    logic               pop;
    logic               head_valid;
    logic [XLEN-1:0]    push_pc;

    assign head_valid     = !rst && (count != {CW{1'b0}});
    assign imem_req_valid = !rst && (state == RUN) && !redirect_valid &&
                            ((CW+1)'(count) + (CW+1)'(outstanding) < (CW+1)'(BUF_DEPTH));
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign push           = imem_rsp_valid && !redirect_valid && (discard == {CW{1'b0}});
    assign pop            = head_valid && !stall && !redirect_valid;
    // Responses return in order, so the oldest in-flight request sits
    // outstanding words behind the current pc.
    assign push_pc        = pc - (XLEN'(outstanding) << 2);

    fetch_buffer #(
        .WIDTH (XLEN + 32),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({push_pc, imem_rsp_data}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count)
    );

    assign instr_valid = head_valid;
    assign instr       = head_valid ? head[31:0] : INSTR_NOP;
    assign instr_pc    = head_valid ? head[XLEN+31:32] : {XLEN{1'b0}};
    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[31:25];
    assign rd          = instr[11:7];
    assign rs1         = instr[19:15];
    assign rs2         = instr[24:20];

    // Fetch state, pc and credit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            outstanding <= {CW{1'b0}};
            discard     <= {CW{1'b0}};
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            outstanding <= outstanding_next;
            discard     <= discard_next;
        end
    end

    // Next-state: a redirect re-targets pc and turns every remaining
    // in-flight request into one to be discarded.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        outstanding_next = outstanding;
        discard_next     = discard;
        case ({accept, imem_rsp_valid})
            2'b10:   outstanding_next = outstanding + CW'(1);
            2'b01:   outstanding_next = outstanding - CW'(1);
            default: outstanding_next = outstanding;
        endcase
        if (redirect_valid) begin
            pc_next      = redirect_pc & ~XLEN'(3);
            discard_next = outstanding_next;
            state_next   = (outstanding_next != {CW{1'b0}}) ? DRAIN : RUN;
        end else begin
            pc_next = accept ? (pc + XLEN'(4)) : pc;
            if (imem_rsp_valid && (discard != {CW{1'b0}})) begin
                discard_next = discard - CW'(1);
            end else begin
                discard_next = discard;
            end
            if ((state == DRAIN) && (discard_next == {CW{1'b0}})) begin
                state_next = RUN;
            end else begin
                state_next = state;
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Push and redirect event counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= 32'd0;
            perf_flushes <= 32'd0;
        end else begin
            perf_fetched <= perf_fetched + (push ? 32'd1 : 32'd0);
            perf_flushes <= perf_flushes + (redirect_valid ? 32'd1 : 32'd0);
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order memory model of
// selectable latency. Perf counters are checked when FETCH_PERF_EN is defined.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd, rs1, rs2;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushes;
`endif

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .instr_valid    (instr_valid),
        .instr_pc       (instr_pc),
        .instr          (instr),
        .opcode         (opcode),
        .funct3         (funct3),
        .funct7         (funct7),
        .rd             (rd),
        .rs1            (rs1),
        .rs2            (rs2)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushes   (perf_flushes)
`endif
    );

    always #5 clk = ~clk;

    // Memory image: word(0)=0x40000033, word(4)=0x40010033, word(8)=0x40020033,
    // word(0x100)=0x40400033, word(0x200)=0x40800033.
    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h4000_0033 ^ {a[17:2], 16'h0000};
    endfunction

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] due;
    } pend_t;

    pend_t       q[$];
    logic [31:0] cyc = 32'd0;
    logic [31:0] lat = 32'd1;
    int          n_checks = 0;
    int          n_pass = 0;

    // In-order memory: a request accepted at edge k is answered lat cycles later.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'd0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                q.push_back('{imem_req_addr, cyc + lat - 32'd1});
            end
            if (q.size() > 0 && q[0].due <= cyc) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= word(q[0].addr);
                void'(q.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
            end
        end
        cyc <= cyc + 32'd1;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; imem_req_ready = 1'b1; redirect_valid = 1'b0;
        redirect_pc = 32'd0; stall = 1'b0;
        step();
        step();
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_instr_valid", 64'(instr_valid), 64'd0);
        check("rst_instr_nop", 64'(instr), 64'h13);
        check("rst_instr_pc", 64'(instr_pc), 64'd0);
        check("rst_opcode", 64'(opcode), 64'h13);
        rst = 1'b0;
        #1;
        check("first_req", {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, 32'h0});

        // First acceptance at the next edge; data visible two cycles later.
        step();
        check("second_req", {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, 32'h4});
        check("lat_not_yet", 64'(instr_valid), 64'd0);
        step();
        check("lat_valid", 64'(instr_valid), 64'd1);
        check("lat_pc", 64'(instr_pc), 64'h0);
        check("lat_instr", 64'(instr), 64'h4000_0033);
        check("lat_opcode", 64'(opcode), 64'b0110011);
        check("lat_funct7", 64'(funct7), 64'b0100000);
        check("lat_funct3", 64'(funct3), 64'd0);
        check("credit_block", 64'(imem_req_valid), 64'd0);

        stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_head_pc", 64'(instr_pc), 64'h0);
        end
        check("stall_no_req", 64'(imem_req_valid), 64'd0);
        check("stall_addr", 64'(imem_req_addr), 64'h8);
        check("stall_instr", 64'(instr), 64'h4000_0033);

        stall = 1'b0;
        step();
        check("pop_pc4", 64'(instr_pc), 64'h4);
        check("pop_instr4", 64'(instr), 64'h4001_0033);
        check("pop_rs1", 64'(rs1), 64'd2);

        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_addr", {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, 32'h8});
        end
        check("drained_empty", 64'(instr_valid), 64'd0);
        imem_req_ready = 1'b1;
        step();
        check("accept_adv", 64'(imem_req_addr), 64'hC);
        step();
        check("pc8", 64'(instr_pc), 64'h8);
        check("rs1_8", 64'(rs1), 64'd4);

        // Quiesce, then build two in-flight requests with a slower memory.
        imem_req_ready = 1'b0;
        step(); step(); step();
        check("quiet_addr", 64'(imem_req_addr), 64'h10);
        check("quiet_empty", 64'(instr_valid), 64'd0);
        lat = 32'd3;
        imem_req_ready = 1'b1;
        step();
        step();
        check("two_out_block", 64'(imem_req_valid), 64'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        #1;
        check("redir_no_req", 64'(imem_req_valid), 64'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        check("drain1_no_req", 64'(imem_req_valid), 64'd0);
        check("drain1_addr", 64'(imem_req_addr), 64'h100);
        step();
        check("drain2_no_req", 64'(imem_req_valid), 64'd0);
        check("drain2_empty", 64'(instr_valid), 64'd0);
        step();
        check("run_req", {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, 32'h100});
        check("stale_dropped", 64'(instr_valid), 64'd0);
        lat = 32'd1;
        step();
        step();
        check("redir_pc", {31'd0, instr_valid, instr_pc}, {31'd0, 1'b1, 32'h100});
        check("redir_instr", 64'(instr), 64'h4040_0033);
        check("redir_rs2", 64'(rs2), 64'd4);

        // Redirect in the same cycle as a response and a pop.
        check("coinc_rsp", 64'(imem_rsp_valid), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0;
        #1;
        check("coinc_flush", 64'(instr_valid), 64'd0);
        check("coinc_req", {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, 32'h200});
        step();
        check("coinc_dropped", 64'(instr_valid), 64'd0);
        step();
        check("coinc_next", {31'd0, instr_valid, instr_pc}, {31'd0, 1'b1, 32'h200});
        check("coinc_instr", 64'(instr), 64'h4080_0033);

        // Reset with data buffered.
        stall = 1'b1;
        step();
        step();
        check("buffered_head", {31'd0, instr_valid, instr_pc}, {31'd0, 1'b1, 32'h200});
`ifdef FETCH_PERF_EN
        check("perf_fetched", 64'(perf_fetched), 64'd7);
        check("perf_flushes", 64'(perf_flushes), 64'd2);
`endif
        rst = 1'b1;
        step();
        check("mid_rst_valid", 64'(instr_valid), 64'd0);
        check("mid_rst_req", 64'(imem_req_valid), 64'd0);
        check("mid_rst_addr", 64'(imem_req_addr), 64'h0);
        check("mid_rst_nop", 64'(instr), 64'h13);
`ifdef FETCH_PERF_EN
        check("perf_fetched_rst", 64'(perf_fetched), 64'd0);
        check("perf_flushes_rst", 64'(perf_flushes), 64'd0);
`endif
        rst = 1'b0;
        stall = 1'b0;
        #1;
        check("restart_req", {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, 32'h0});
        step();
        step();
        check("restart_head", {31'd0, instr_valid, instr_pc}, {31'd0, 1'b1, 32'h0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
